// File: rtl/jtagtap_multi.sv
// jtagtap_multi: IEEE 1149.1 TAP with RISC-V DTM (dtmcontrol/dbus) front end and user scan chains.
// Build macro JTAGTAP_USER_CHAINS_EN enables user chains at IR 0x12+k; without it those codes are BYPASS.
module jtagtap_multi #(
    parameter logic [31:0] idcode    = 32'h10e31913,
    parameter int          abits     = 7,
    parameter int          irlen     = 5,
    parameter logic [2:0]  idle_hint = 3'd1,
    parameter int          nuser     = 2,
    parameter int          uwidth    = 32
) (
    input  logic                    i_tck,
    input  logic                    i_trst,
    input  logic                    i_tms,
    input  logic                    i_tdi,
    output logic                    o_tdo,
    output logic                    o_dmi_req_valid,
    output logic                    o_dmi_req_write,
    output logic [abits-1:0]        o_dmi_req_addr,
    output logic [31:0]             o_dmi_req_data,
    input  logic [31:0]             i_dmi_resp_data,
    input  logic                    i_dmi_busy,
    input  logic                    i_dmi_error,
    output logic                    o_dmi_reset,
    output logic                    o_dmi_hardreset,
    output logic [nuser-1:0]        o_user_sel,
    output logic                    o_user_capture,
    output logic                    o_user_update,
    output logic [uwidth-1:0]       o_user_wdata,
    input  logic [nuser*uwidth-1:0] i_user_rdata
);
    localparam int DBW = abits + 34;
    localparam int DRW = (DBW > uwidth) ? DBW : uwidth;
    localparam logic [irlen-1:0] IR_IDCODE = irlen'(5'h01);
    localparam logic [irlen-1:0] IR_DTMCS  = irlen'(5'h10);
    localparam logic [irlen-1:0] IR_DBUS   = irlen'(5'h11);
    localparam logic [7:0] LEN_DBUS = 8'(DBW);
    localparam logic [7:0] LEN_USER = 8'(uwidth);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    tap_state_t        state_reg, state_next;
    logic [irlen-1:0]  ir_reg, ir_shift_reg;
    logic [DRW-1:0]    dr_reg, dr_shift, dr_capture;
    logic [1:0]        dmistat_reg;
    logic [abits-1:0]  dmi_addr_reg;
    logic              tdo_reg;
    logic [7:0]        dr_len;
    logic              sel_idcode, sel_dtmcs, sel_dbus, sel_user;
    logic [nuser-1:0]  user_hit;
    logic [uwidth-1:0] user_rdata_sel;
    logic [1:0]        live_stat;
    logic [1:0]        dbus_op;
    logic [31:0]       dbus_data;
    logic [abits-1:0]  dbus_addr;
    logic              dmi_issue;

    // TAP state register and next-state logic
    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:      state_next = i_tms ? TLR      : RTI;
            RTI:      state_next = i_tms ? SEL_DR   : RTI;
            SEL_DR:   state_next = i_tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = i_tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_next = i_tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_next = i_tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = i_tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_next = i_tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_next = i_tms ? SEL_DR   : RTI;
            SEL_IR:   state_next = i_tms ? TLR      : CAP_IR;
            CAP_IR:   state_next = i_tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_next = i_tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_next = i_tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = i_tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_next = i_tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_next = i_tms ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

`ifdef JTAGTAP_USER_CHAINS_EN
    generate
        for (genvar gi = 0; gi < nuser; gi++) begin : g_user_hit
            assign user_hit[gi] = (ir_reg == irlen'(5'h12 + gi));
        end
    endgenerate

    always_comb begin
        user_rdata_sel = '0;
        for (int k = 0; k < nuser; k++) begin
            if (user_hit[k]) begin
                user_rdata_sel = i_user_rdata[k*uwidth +: uwidth];
            end
        end
    end
`else
    logic unused_user_rdata;
    assign user_hit          = '0;
    assign user_rdata_sel    = '0;
    assign unused_user_rdata = ^i_user_rdata;
`endif

    assign sel_idcode = (ir_reg == IR_IDCODE);
    assign sel_dtmcs  = (ir_reg == IR_DTMCS);
    assign sel_dbus   = (ir_reg == IR_DBUS);
    assign sel_user   = |user_hit;
    assign live_stat  = i_dmi_busy ? 2'd3 : (i_dmi_error ? 2'd2 : 2'd0);

    assign dbus_op   = dr_reg[1:0];
    assign dbus_data = dr_reg[33:2];
    assign dbus_addr = dr_reg[DBW-1:34];

    // Selected DR length and parallel capture value; anything undecoded is the 1-bit bypass
    always_comb begin
        dr_len     = 8'd1;
        dr_capture = '0;
        if (sel_dbus) begin
            dr_len = LEN_DBUS;
            dr_capture[DBW-1:0] = {dmi_addr_reg, i_dmi_resp_data, dmistat_reg | live_stat};
        end else if (sel_idcode) begin
            dr_len = 8'd32;
            dr_capture[31:0] = idcode;
        end else if (sel_dtmcs) begin
            dr_len = 8'd32;
            dr_capture[31:0] = {17'b0, idle_hint, dmistat_reg, 6'(abits), 4'h1};
        end else if (sel_user) begin
            dr_len = LEN_USER;
            dr_capture[uwidth-1:0] = user_rdata_sel;
        end
    end

    // TDI enters at the top of the active length; bits above it are don't-care until next capture
    generate
        for (genvar gi = 0; gi < DRW; gi++) begin : g_dr_shift
            if (gi == DRW - 1) begin : g_top
                assign dr_shift[gi] = (dr_len == 8'(gi + 1)) ? i_tdi : 1'b0;
            end else begin : g_mid
                assign dr_shift[gi] = (dr_len == 8'(gi + 1)) ? i_tdi : dr_reg[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            dr_reg       <= DRW'(idcode);
            ir_shift_reg <= IR_IDCODE;
        end else begin
            if (state_reg == CAP_DR) begin
                dr_reg <= dr_capture;
            end else if (state_reg == SHIFT_DR) begin
                dr_reg <= dr_shift;
            end
            if (state_reg == CAP_IR) begin
                ir_shift_reg <= {ir_reg[irlen-1:2], 2'b01};
            end else if (state_reg == SHIFT_IR) begin
                ir_shift_reg <= {i_tdi, ir_shift_reg[irlen-1:1]};
            end
        end
    end

    // dmistat only latches from clean, so BUSY can never be downgraded to FAILED
    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            dmistat_reg  <= 2'd0;
            dmi_addr_reg <= '0;
        end else begin
            if (state_reg == CAP_DR && sel_dbus && dmistat_reg == 2'd0) begin
                dmistat_reg <= live_stat;
            end else if (o_dmi_reset || o_dmi_hardreset) begin
                dmistat_reg <= 2'd0;
            end
            if (dmi_issue) begin
                dmi_addr_reg <= dbus_addr;
            end
        end
    end

    always_ff @(negedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            ir_reg  <= IR_IDCODE;
            tdo_reg <= idcode[0];
        end else begin
            if (state_reg == TLR) begin
                ir_reg <= IR_IDCODE;
            end else if (state_reg == UPD_IR) begin
                ir_reg <= ir_shift_reg;
            end
            tdo_reg <= (state_reg == SHIFT_IR) ? ir_shift_reg[0] : dr_reg[0];
        end
    end

    assign o_tdo = tdo_reg;
    assign dmi_issue = (state_reg == UPD_DR) && sel_dbus && (dmistat_reg == 2'd0) &&
                       ((dbus_op == 2'd1) || (dbus_op == 2'd2));

    // Strobes are decoded from registered state, so each lasts exactly one i_tck cycle
    always_comb begin
        o_dmi_req_valid = 1'b0;
        o_dmi_req_write = 1'b0;
        o_dmi_req_addr  = '0;
        o_dmi_req_data  = '0;
        o_dmi_reset     = 1'b0;
        o_dmi_hardreset = 1'b0;
        o_user_capture  = 1'b0;
        o_user_update   = 1'b0;
        o_user_wdata    = '0;
        if (dmi_issue) begin
            o_dmi_req_valid = 1'b1;
            o_dmi_req_write = (dbus_op == 2'd2);
            o_dmi_req_addr  = dbus_addr;
            o_dmi_req_data  = dbus_data;
        end
        if (state_reg == UPD_DR && sel_dtmcs) begin
            o_dmi_reset     = dr_reg[16];
            o_dmi_hardreset = dr_reg[17];
        end
        if (sel_user) begin
            o_user_capture = (state_reg == CAP_DR);
            o_user_update  = (state_reg == UPD_DR);
            if (state_reg == UPD_DR) begin
                o_user_wdata = dr_reg[uwidth-1:0];
            end
        end
    end

    assign o_user_sel = user_hit;

endmodule

// File: tb/tb_jtagtap_multi.sv
// Directed bench for jtagtap_multi: IDCODE, DTMCONTROL, DBUS requests/sticky status, user chains, resets.
module tb_jtagtap_multi;
    localparam int ABITS  = 7;
    localparam int NUSER  = 2;
    localparam int UWIDTH = 32;

    logic                    i_tck;
    logic                    i_trst;
    logic                    i_tms;
    logic                    i_tdi;
    logic                    o_tdo;
    logic                    o_dmi_req_valid;
    logic                    o_dmi_req_write;
    logic [ABITS-1:0]        o_dmi_req_addr;
    logic [31:0]             o_dmi_req_data;
    logic [31:0]             i_dmi_resp_data;
    logic                    i_dmi_busy;
    logic                    i_dmi_error;
    logic                    o_dmi_reset;
    logic                    o_dmi_hardreset;
    logic [NUSER-1:0]        o_user_sel;
    logic                    o_user_capture;
    logic                    o_user_update;
    logic [UWIDTH-1:0]       o_user_wdata;
    logic [NUSER*UWIDTH-1:0] i_user_rdata;

    jtagtap_multi #(
        .idcode(32'h10e31913), .abits(ABITS), .irlen(5),
        .idle_hint(3'd1), .nuser(NUSER), .uwidth(UWIDTH)
    ) dut (
        .i_tck(i_tck), .i_trst(i_trst), .i_tms(i_tms), .i_tdi(i_tdi), .o_tdo(o_tdo),
        .o_dmi_req_valid(o_dmi_req_valid), .o_dmi_req_write(o_dmi_req_write),
        .o_dmi_req_addr(o_dmi_req_addr), .o_dmi_req_data(o_dmi_req_data),
        .i_dmi_resp_data(i_dmi_resp_data), .i_dmi_busy(i_dmi_busy), .i_dmi_error(i_dmi_error),
        .o_dmi_reset(o_dmi_reset), .o_dmi_hardreset(o_dmi_hardreset),
        .o_user_sel(o_user_sel), .o_user_capture(o_user_capture), .o_user_update(o_user_update),
        .o_user_wdata(o_user_wdata), .i_user_rdata(i_user_rdata)
    );

    initial i_tck = 1'b0;
    always #5 i_tck = ~i_tck;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // strobe monitor, sampled mid-cycle on the falling edge
    int req_cnt = 0, rst_cnt = 0, hrst_cnt = 0, ucap_cnt = 0, uupd_cnt = 0;
    logic             last_write = 1'b0;
    logic [ABITS-1:0] last_addr = '0;
    logic [31:0]      last_data = '0;
    logic [31:0]      last_wdata = '0;
    always @(negedge i_tck) begin
        if (o_dmi_req_valid) begin
            req_cnt++;
            last_write = o_dmi_req_write;
            last_addr  = o_dmi_req_addr;
            last_data  = o_dmi_req_data;
        end
        if (o_dmi_reset) rst_cnt++;
        if (o_dmi_hardreset) hrst_cnt++;
        if (o_user_capture) ucap_cnt++;
        if (o_user_update) begin
            uupd_cnt++;
            last_wdata = o_user_wdata;
        end
    end

    int req_base, rst_base, hrst_base, ucap_base, uupd_base;

    task automatic snap();
        req_base  = req_cnt;
        rst_base  = rst_cnt;
        hrst_base = hrst_cnt;
        ucap_base = ucap_cnt;
        uupd_base = uupd_cnt;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dbus(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic step(input logic tms, input logic tdi, output logic tdo);
        @(negedge i_tck);
        #1;
        tdo   = o_tdo;
        i_tms = tms;
        i_tdi = tdi;
        @(posedge i_tck);
        #1;
    endtask

    task automatic move(input logic tms);
        logic d;
        step(tms, 1'b0, d);
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] cap);
        logic b;
        move(1'b1);
        move(1'b1);
        move(1'b0);
        move(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, v[i], b);
            cap[i] = b;
        end
        move(1'b1);
        move(1'b0);
        $display("IR scan in=%h captured=%h", v, cap);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int len, input int pause_at,
                           output logic [63:0] dout);
        logic b;
        dout = '0;
        move(1'b1);
        move(1'b0);
        move(1'b0);
        for (int i = 0; i < len; i++) begin
            step((i == len - 1) || (pause_at > 0 && i == pause_at - 1), din[i], b);
            dout[i] = b;
            if (pause_at > 0 && i == pause_at - 1 && i != len - 1) begin
                move(1'b0);
                move(1'b0);
                move(1'b1);
                move(1'b0);
            end
        end
        move(1'b1);
        move(1'b0);
        $display("DR scan len=%0d in=%h out=%h", len, din, dout);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [4:0]  cap;
    logic [63:0] d;

    initial begin
        i_trst = 1'b1; i_tms = 1'b1; i_tdi = 1'b0;
        i_dmi_resp_data = '0; i_dmi_busy = 1'b0; i_dmi_error = 1'b0;
        i_user_rdata = {32'hA5A5A5A5, 32'h5A5A0F0F};
        repeat (2) @(negedge i_tck);
        #1;
        check("rst_tdo", 64'(o_tdo), 64'h1);
        check("rst_req_valid", 64'(o_dmi_req_valid), 64'h0);
        check("rst_req_data", 64'(o_dmi_req_data), 64'h0);
        check("rst_user_sel", 64'(o_user_sel), 64'h0);
        check("rst_user_wdata", 64'(o_user_wdata), 64'h0);
        @(negedge i_tck);
        i_trst = 1'b0;
        i_tms  = 1'b0;
        move(1'b0);

        scan_dr(64'h0, 32, 0, d);
        check("idcode", d, 64'h10e31913);

        snap();
        scan_ir(5'h10, cap);
        check("ir_capture", 64'(cap), 64'h01);
        scan_dr(64'h0, 32, 0, d);
        check("dtmcs_read", d, 64'h1071);
        check("dtmcs_no_reset", 64'(rst_cnt - rst_base), 64'h0);

        scan_ir(5'h11, cap);
        check("ir_capture_prev", 64'(cap), 64'h11);
        i_dmi_resp_data = 32'hCAFEF00D;
        snap();
        scan_dr(dbus(7'h10, 32'h1, 2'd2), 41, 0, d);
        check("dbus_cap0", d, dbus(7'h00, 32'hCAFEF00D, 2'd0));
        check("wr_req_cnt", 64'(req_cnt - req_base), 64'h1);
        check("wr_req_write", 64'(last_write), 64'h1);
        check("wr_req_addr", 64'(last_addr), 64'h10);
        check("wr_req_data", 64'(last_data), 64'h1);

        i_dmi_resp_data = 32'h12345678;
        snap();
        scan_dr(dbus(7'h7f, 32'hFFFFFFFF, 2'd0), 41, 0, d);
        check("dbus_addr_latched", d, dbus(7'h10, 32'h12345678, 2'd0));
        check("nop_no_req", 64'(req_cnt - req_base), 64'h0);

        i_dmi_busy = 1'b1;
        snap();
        scan_dr(dbus(7'h05, 32'h0, 2'd1), 41, 0, d);
        check("busy_cap", d, dbus(7'h10, 32'h12345678, 2'd3));
        i_dmi_busy = 1'b0;
        scan_dr(dbus(7'h05, 32'h0, 2'd1), 41, 0, d);
        check("busy_sticky", d, dbus(7'h10, 32'h12345678, 2'd3));
        i_dmi_error = 1'b1;
        scan_dr(dbus(7'h05, 32'h0, 2'd1), 41, 0, d);
        check("busy_not_overwritten", d, dbus(7'h10, 32'h12345678, 2'd3));
        i_dmi_error = 1'b0;
        check("busy_no_req", 64'(req_cnt - req_base), 64'h0);

        scan_ir(5'h10, cap);
        snap();
        scan_dr(64'h00010000, 32, 0, d);
        check("dtmcs_busy_stat", d, 64'h1C71);
        check("dmireset_pulse", 64'(rst_cnt - rst_base), 64'h1);
        check("dmireset_no_hard", 64'(hrst_cnt - hrst_base), 64'h0);
        scan_dr(64'h0, 32, 0, d);
        check("dtmcs_cleared", d, 64'h1071);

        scan_ir(5'h11, cap);
        i_dmi_error = 1'b1;
        snap();
        scan_dr(dbus(7'h06, 32'h0, 2'd1), 41, 0, d);
        check("error_cap", d, dbus(7'h10, 32'h12345678, 2'd2));
        check("error_no_req", 64'(req_cnt - req_base), 64'h0);
        i_dmi_error = 1'b0;
        scan_ir(5'h10, cap);
        snap();
        scan_dr(64'h00020000, 32, 0, d);
        check("dtmcs_err_stat", d, 64'h1871);
        check("hardreset_pulse", 64'(hrst_cnt - hrst_base), 64'h1);
        check("hardreset_no_reset", 64'(rst_cnt - rst_base), 64'h0);
        scan_dr(64'h0, 32, 0, d);
        check("dtmcs_cleared2", d, 64'h1071);

        scan_ir(5'h11, cap);
        snap();
        scan_dr(dbus(7'h03, 32'hDEADBEEF, 2'd1), 41, 17, d);
        check("pause_cap", d, dbus(7'h10, 32'h12345678, 2'd0));
        check("rd_req_cnt", 64'(req_cnt - req_base), 64'h1);
        check("rd_req_write", 64'(last_write), 64'h0);
        check("rd_req_addr", 64'(last_addr), 64'h03);
        check("rd_req_data", 64'(last_data), 64'hDEADBEEF);

        scan_ir(5'h13, cap);
        snap();
        scan_dr(64'h12345678, 32, 0, d);
`ifdef JTAGTAP_USER_CHAINS_EN
        check("user_sel", 64'(o_user_sel), 64'h2);
        check("user_tdo", d, 64'hA5A5A5A5);
        check("user_capture", 64'(ucap_cnt - ucap_base), 64'h1);
        check("user_update", 64'(uupd_cnt - uupd_base), 64'h1);
        check("user_wdata", 64'(last_wdata), 64'h12345678);
`else
        check("user_sel", 64'(o_user_sel), 64'h0);
        check("user_bypass_tdo", d, 64'h2468ACF0);
        check("user_capture", 64'(ucap_cnt - ucap_base), 64'h0);
        check("user_update", 64'(uupd_cnt - uupd_base), 64'h0);
`endif

        scan_ir(5'h1f, cap);
        scan_dr(64'h3, 4, 0, d);
        check("bypass_1f", d, 64'h6);

        scan_ir(5'h10, cap);
        repeat (5) move(1'b1);
        move(1'b0);
        scan_dr(64'h0, 32, 0, d);
        check("tms_reset_idcode", d, 64'h10e31913);

        scan_ir(5'h11, cap);
        i_dmi_busy = 1'b1;
        snap();
        move(1'b1);
        move(1'b0);
        move(1'b0);
        for (int i = 0; i < 20; i++) begin
            logic b;
            logic [63:0] din;
            din = dbus(7'h22, 32'h55, 2'd2);
            step(1'b0, din[i], b);
        end
        i_dmi_busy = 1'b0;
        i_trst = 1'b1;
        #1;
        check("trst_req_valid", 64'(o_dmi_req_valid), 64'h0);
        check("trst_tdo", 64'(o_tdo), 64'h1);
        @(negedge i_tck);
        i_trst = 1'b0;
        i_tms  = 1'b0;
        move(1'b0);
        check("trst_no_req", 64'(req_cnt - req_base), 64'h0);
        scan_dr(64'h0, 32, 0, d);
        check("trst_idcode", d, 64'h10e31913);
        scan_ir(5'h10, cap);
        scan_dr(64'h0, 32, 0, d);
        check("trst_dmistat", d, 64'h1071);
        scan_ir(5'h11, cap);
        i_dmi_resp_data = 32'h0;
        scan_dr(64'h0, 41, 0, d);
        check("trst_dmi_addr", d, dbus(7'h00, 32'h0, 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
